// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Receives a length-prefixed little-endian program image over a
//            valid/ready byte stream, writes it word by word into the
//            instruction memory and holds the CPU core in reset until the
//            image is complete.
// Options  : IMEM_BOOT_CHECKSUM_EN - adds a trailing XOR checksum byte that
//            must match the data bytes before the core is released.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  // Largest legal word count: the full memory.
  localparam logic [31:0] c_capacity = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
`ifdef IMEM_BOOT_CHECKSUM_EN
    , S_CSUM = 3'd7
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  state_t            w_fin_state;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_idx;
  logic [1:0]        r_byte_idx;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_words_loaded;
  logic              w_xfer;
  logic [15:0]       w_len_full;
  logic [ADDR_W:0]   w_idx_next;
  logic              w_last_word;
  logic              w_start_ok;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  assign w_xfer      = rx_valid & rx_ready;
  assign w_len_full  = {rx_data, r_len[7:0]};
  assign w_idx_next  = r_idx + 1'b1;
  assign w_last_word = (32'(w_idx_next) == 32'(r_len));
  // start is honoured only while no load is in progress.
  assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_DONE) |
                                (r_state == S_ERR));

  // The state reached once all data words are in (or len was zero).
`ifdef IMEM_BOOT_CHECKSUM_EN
  assign w_fin_state = S_CSUM;
`else
  assign w_fin_state = S_DONE;
`endif

  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign words_loaded = r_words_loaded;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state selection and state-decoded outputs.
  always_comb begin
    w_next_state = r_state;
    rx_ready     = 1'b0;
    imem_we      = 1'b0;
    cpu_reset    = 1'b1;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (w_xfer) w_next_state = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (w_xfer) begin
          if (w_len_full == 16'd0)                  w_next_state = w_fin_state;
          else if (32'(w_len_full) > c_capacity)    w_next_state = S_ERR;
          else                                      w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (w_xfer && (r_byte_idx == 2'd3)) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
        w_next_state = w_last_word ? w_fin_state : S_DATA;
      end
      S_DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        if (start) w_next_state = S_LEN_LO;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) w_next_state = S_LEN_LO;
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (w_xfer) w_next_state = (rx_data == r_csum) ? S_DONE : S_ERR;
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  // Length capture, byte assembly, write-port registers and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len          <= '0;
      r_idx          <= '0;
      r_byte_idx     <= '0;
      r_word         <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_words_loaded <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      r_csum         <= '0;
`endif
    end else begin
      if (w_start_ok) begin
        r_len          <= '0;
        r_idx          <= '0;
        r_byte_idx     <= '0;
        r_word         <= '0;
        r_words_loaded <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        r_csum         <= '0;
`endif
      end
      if (w_xfer && (r_state == S_LEN_LO)) r_len[7:0]  <= rx_data;
      if (w_xfer && (r_state == S_LEN_HI)) r_len[15:8] <= rx_data;
      if (w_xfer && (r_state == S_DATA)) begin
        r_word[{r_byte_idx, 3'b000} +: 8] <= rx_data;
        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
        r_csum     <= r_csum ^ rx_data;
`endif
        // Latch the finished word so the write port holds it past WRITE.
        if (r_byte_idx == 2'd3) begin
          r_addr  <= r_idx[ADDR_W-1:0];
          r_wdata <= {rx_data, r_word[23:0]};
        end
      end
      if (r_state == S_WRITE) begin
        r_idx          <= w_idx_next;
        r_words_loaded <= r_words_loaded + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Directed scoreboard bench for imem_boot_loader (ADDR_W = 8).
//            Expected memory writes are queued as images are sent; a monitor
//            pops and compares on every write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  int checks   = 0;
  int failures = 0;
  int n_writes = 0;

  logic [39:0] exp_q[$];   // {addr, data}
  logic [31:0] img[$];     // words of the image being sent

  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      logic [39:0] e;
      n_writes++;
      check("we_rx_ready", rx_ready, 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e[39:32]);
        check("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    cnt = 0;
    while (!rx_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) check("byte_accept_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Sends len, the words in img (little-endian) and, when enabled, the
  // XOR trailer; queues the expected writes starting at address 0.
  task automatic send_image(input logic [15:0] len, input int gap, input bit trailer);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < img.size(); i++) exp_q.push_back({i[7:0], img[i]});
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    for (int i = 0; i < img.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(img[i][8*k +: 8], gap);
        x = x ^ img[i][8*k +: 8];
      end
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    if (trailer) send_byte(x, gap);
`else
    if (trailer) x = 8'h00;
`endif
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int cnt;
    cnt = 0;
    while (!(done || err) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) check("wait_end_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_words", words_loaded, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic two-word load.
    pulse_start();
    check("basic_busy", busy, 1);
    img = '{32'h00100513, 32'h00200593};
    send_image(16'd2, 0, 1'b1);
`ifndef IMEM_BOOT_CHECKSUM_EN
    check("basic_last_we", imem_we, 1);
    check("basic_cpu_rst_at_we", cpu_reset, 1);
    @(negedge clk);
    check("basic_cpu_rst_fall", cpu_reset, 0);
`endif
    wait_end();
    check("basic_done", done, 1);
    check("basic_cpu_reset", cpu_reset, 0);
    check("basic_words", words_loaded, 2);
    check("basic_sb_empty", exp_q.size(), 0);

    // Restart from DONE, then the same image with 3-cycle gaps.
    pulse_start();
    check("restart_cpu_reset", cpu_reset, 1);
    check("restart_done", done, 0);
    check("restart_words", words_loaded, 0);
    send_image(16'd2, 3, 1'b1);
    wait_end();
    check("gap_done", done, 1);
    check("gap_words", words_loaded, 2);
    check("gap_sb_empty", exp_q.size(), 0);

    // len = 0: straight to completion, no writes.
    w0 = n_writes;
    pulse_start();
    img = {};
    send_image(16'd0, 0, 1'b1);
    wait_end();
    check("len0_done", done, 1);
    check("len0_writes", n_writes - w0, 0);
    check("len0_words", words_loaded, 0);

    // len = 257: too large.
    w0 = n_writes;
    pulse_start();
    send_image(16'h0101, 0, 1'b0);
    wait_end();
    check("len257_err", err, 1);
    check("len257_cpu_reset", cpu_reset, 1);
    check("len257_done", done, 0);
    check("len257_rx_ready", rx_ready, 0);
    check("len257_writes", n_writes - w0, 0);

    // len = 256: fills the whole memory, starting from ERR.
    w0 = n_writes;
    pulse_start();
    check("from_err_err", err, 0);
    for (int i = 0; i < 256; i++) img.push_back({8'hA5 ^ i[7:0], i[7:0], ~i[7:0], i[7:0]});
    send_image(16'h0100, 0, 1'b1);
    wait_end();
    check("len256_done", done, 1);
    check("len256_writes", n_writes - w0, 256);
    check("len256_words", words_loaded, 256);
    check("len256_last_addr", imem_addr, 8'hFF);
    check("len256_last_data", imem_wdata, 32'h5AFF00FF);
    check("len256_sb_empty", exp_q.size(), 0);

    // Reset after two data bytes of word 1.
    pulse_start();
    exp_q.push_back({8'h00, 32'h00100513});
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h05, 0);
    rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_cpu_reset", cpu_reset, 1);
    check("midrst_words", words_loaded, 0);
    check("midrst_rx_ready", rx_ready, 0);
    check("midrst_sb_empty", exp_q.size(), 0);
    @(negedge clk);

    // Fresh load with a start pulse injected during DATA.
    pulse_start();
    exp_q.push_back({8'h00, 32'h00100513});
    exp_q.push_back({8'h01, 32'h00200593});
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h13, 0); send_byte(8'h05, 0);
    rx_valid = 1'b0;
    pulse_start();
    check("ign_start_busy", busy, 1);
    check("ign_start_rx_ready", rx_ready, 1);
    send_byte(8'h10, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h05, 0); send_byte(8'h20, 0); send_byte(8'h00, 0);
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(8'hB0, 0);
`endif
    rx_valid = 1'b0;
    wait_end();
    check("reload_done", done, 1);
    check("reload_words", words_loaded, 2);
    check("reload_sb_empty", exp_q.size(), 0);

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum: correct trailer 00, then wrong trailer 01.
    pulse_start();
    exp_q.push_back({8'h00, 32'hF00F55AA});
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'h55, 0); send_byte(8'h0F, 0); send_byte(8'hF0, 0);
    send_byte(8'h00, 0);
    rx_valid = 1'b0;
    wait_end();
    check("csum_ok_done", done, 1);
    check("csum_ok_err", err, 0);
    pulse_start();
    exp_q.push_back({8'h00, 32'hF00F55AA});
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'h55, 0); send_byte(8'h0F, 0); send_byte(8'hF0, 0);
    send_byte(8'h01, 0);
    rx_valid = 1'b0;
    wait_end();
    check("csum_bad_err", err, 1);
    check("csum_bad_cpu_reset", cpu_reset, 1);
    check("csum_bad_done", done, 0);
`endif

    repeat (2) @(negedge clk);
    check("final_sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
